ltc_wr_arbiter: RTL and testbench

Shares the single write port of the mainboard 48-bit LTC counter between two requesters: the ICM time-transfer decoder and host software register writes. It sequences each accepted write into a one-cycle LTC load and compensates the load value for commit latency. It enforces a post-write holdoff and reports per-write correction statistics. It sits between `icm_time_transfer` / the register file and the LTC counter.

---
 rtl/ltc_pkg.sv | 13 +
 rtl/ltc_wr_stats.sv | 34 +++
 rtl/ltc_wr_arbiter.sv | 117 +++++++++++
 tb/tb_ltc_wr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ltc_pkg.sv
// Shared types and constants for the LTC write arbiter and its statistics block.
package ltc_pkg;
  localparam int LTC_W = 48;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMMIT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_e;

  localparam logic SRC_ICM = 1'b0;
  localparam logic SRC_SW  = 1'b1;
endpackage

// File: rtl/ltc_wr_stats.sv
// Per-load statistics: wrapping load counter and the correction applied by each load.
module ltc_wr_stats import ltc_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LTC_W-1:0] load_data_i,
  input  logic [LTC_W-1:0] ltc_i,
  output logic [15:0]      wr_cnt_o,
  output logic [LTC_W-1:0] last_delta_o,
  output logic             delta_valid_o
);
  logic [15:0]      cnt_q;
  logic [LTC_W-1:0] delta_q;
  logic             dvld_q;

  // Without the load the counter would have advanced to ltc+1; delta is the jump relative to that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      delta_q <= '0;
      dvld_q  <= 1'b0;
    end else begin
      dvld_q <= load_i;
      if (load_i) begin
        cnt_q   <= cnt_q + 16'd1;
        delta_q <= load_data_i - ltc_i - LTC_W'(1);
      end
    end
  end

  assign wr_cnt_o      = cnt_q;
  assign last_delta_o  = delta_q;
  assign delta_valid_o = dvld_q;
endmodule

// File: rtl/ltc_wr_arbiter.sv
// Arbitrates ICM and software writes onto the single LTC load port, with post-load holdoff.
// Optional statistics (wr_cnt, last_delta, delta_valid) are built when LTC_WR_ARB_STATS_EN is defined.
module ltc_wr_arbiter import ltc_pkg::*; #(
  parameter logic [LTC_W-1:0] COMMIT_ADJ  = LTC_W'(1),
  parameter int unsigned      HOLDOFF_CNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LTC_W-1:0] ltc,
  input  logic             icm_wr_req,
  input  logic [LTC_W-1:0] icm_wr_data,
  input  logic             icm_rdy,
  input  logic             sw_wr_req,
  input  logic [LTC_W-1:0] sw_wr_data,
  input  logic             sw_force,
  output logic             ltc_load,
  output logic [LTC_W-1:0] ltc_load_data,
  output logic             sw_wr_ack,
  output logic             sw_wr_nack,
  output logic             busy,
  output logic             last_src,
  output logic             icm_overrun,
  output logic [15:0]      wr_cnt,
  output logic [LTC_W-1:0] last_delta,
  output logic             delta_valid
);
  state_e           state_q, state_d;
  logic [15:0]      hold_q;
  logic             pend_vld_q, pend_vld_d;
  logic [LTC_W-1:0] pend_data_q;
  logic [LTC_W-1:0] load_data_q;
  logic             src_q, ack_q, nack_q, ovr_q;
  logic             idle, icm_take, sw_accept;
  logic [LTC_W-1:0] job_data;

  assign idle      = (state_q == S_IDLE);
  assign icm_take  = idle && (pend_vld_q || icm_wr_req);
  assign sw_accept = idle && sw_wr_req && !pend_vld_q && !icm_wr_req && (!icm_rdy || sw_force);
  // The older pending request is served first; a same-cycle arrival then stays pending.
  assign job_data  = icm_take ? (pend_vld_q ? pend_data_q : icm_wr_data) : sw_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (icm_take || sw_accept) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_HOLDOFF;
      S_HOLDOFF: if (hold_q == 16'd0) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ltc_load = (state_q == S_COMMIT);
    busy     = !idle || pend_vld_q;
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    if (icm_take) pend_vld_d = 1'b0;
    if (icm_wr_req && !(icm_take && !pend_vld_q)) pend_vld_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      load_data_q <= '0;
      src_q       <= SRC_ICM;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      if (icm_wr_req) pend_data_q <= icm_wr_data;
      if (icm_wr_req && pend_vld_q && !icm_take) ovr_q <= 1'b1;
      if (icm_take || sw_accept) begin
        load_data_q <= job_data + COMMIT_ADJ;
        src_q       <= icm_take ? SRC_ICM : SRC_SW;
      end
      ack_q  <= sw_accept;
      nack_q <= sw_wr_req && !sw_accept;
      if (state_q == S_COMMIT)                        hold_q <= 16'(HOLDOFF_CNT - 1);
      else if (state_q == S_HOLDOFF && hold_q != '0)  hold_q <= hold_q - 16'd1;
    end
  end

  assign ltc_load_data = load_data_q;
  assign last_src      = src_q;
  assign sw_wr_ack     = ack_q;
  assign sw_wr_nack    = nack_q;
  assign icm_overrun   = ovr_q;

`ifdef LTC_WR_ARB_STATS_EN
  ltc_wr_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ltc_load),
    .load_data_i  (load_data_q),
    .ltc_i        (ltc),
    .wr_cnt_o     (wr_cnt),
    .last_delta_o (last_delta),
    .delta_valid_o(delta_valid)
  );
`else
  logic unused_ltc;
  assign unused_ltc  = ^ltc;
  assign wr_cnt      = '0;
  assign last_delta  = '0;
  assign delta_valid = 1'b0;
`endif
endmodule

// File: tb/tb_ltc_wr_arbiter.sv
// Directed self-checking bench for ltc_wr_arbiter (default parameters, HOLDOFF_CNT=16).
module tb_ltc_wr_arbiter;
  localparam int H = 16;
`ifdef LTC_WR_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] ltc, icm_wr_data, sw_wr_data;
  logic        icm_wr_req, icm_rdy, sw_wr_req, sw_force;
  logic        ltc_load, sw_wr_ack, sw_wr_nack, busy, last_src, icm_overrun, delta_valid;
  logic [47:0] ltc_load_data, last_delta;
  logic [15:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int loads    = 0;

  always #5 clk = ~clk;

  ltc_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ltc(ltc),
    .icm_wr_req(icm_wr_req), .icm_wr_data(icm_wr_data), .icm_rdy(icm_rdy),
    .sw_wr_req(sw_wr_req), .sw_wr_data(sw_wr_data), .sw_force(sw_force),
    .ltc_load(ltc_load), .ltc_load_data(ltc_load_data),
    .sw_wr_ack(sw_wr_ack), .sw_wr_nack(sw_wr_nack), .busy(busy),
    .last_src(last_src), .icm_overrun(icm_overrun),
    .wr_cnt(wr_cnt), .last_delta(last_delta), .delta_valid(delta_valid)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_timeout busy=%b after %0d cycles", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; icm_wr_req = 0; sw_wr_req = 0; icm_rdy = 0; sw_force = 0;
    icm_wr_data = '0; sw_wr_data = '0; ltc = '0;
    #3;
    n_checks++;
    if ({ltc_load, sw_wr_ack, sw_wr_nack, busy, last_src, icm_overrun, delta_valid} !== 7'b0 ||
        ltc_load_data !== '0 || wr_cnt !== '0 || last_delta !== '0) begin
      n_fail++; $display("FAIL reset_outputs load=%b ack=%b nack=%b busy=%b src=%b ovr=%b data=%h cnt=%0d delta=%h exp all 0",
        ltc_load, sw_wr_ack, sw_wr_nack, busy, last_src, icm_overrun, ltc_load_data, wr_cnt, last_delta);
    end
    step(); step(); rst_n = 1'b1; step();
  endtask

  task automatic test_icm_load();
    ltc = 48'h0FF0; icm_wr_req = 1; icm_wr_data = 48'h1000;
    step(); icm_wr_req = 0; loads++;
    n_checks++;
    if (ltc_load !== 1'b1 || ltc_load_data !== 48'h1001 || last_src !== 1'b0) begin
      n_fail++; $display("FAIL icm_load load=%b data=%h src=%b exp 1 1001 0", ltc_load, ltc_load_data, last_src);
    end
    step();
    n_checks++;
    if (ltc_load !== 1'b0 || ltc_load_data !== 48'h1001) begin
      n_fail++; $display("FAIL icm_load_hold load=%b data=%h exp 0 1001", ltc_load, ltc_load_data);
    end
    n_checks++;
    if (wr_cnt !== (STATS ? 16'd1 : 16'd0) || last_delta !== (STATS ? 48'h10 : 48'h0) || delta_valid !== STATS) begin
      n_fail++; $display("FAIL icm_stats cnt=%0d delta=%h dv=%b exp %0d %h %b",
        wr_cnt, last_delta, delta_valid, STATS ? 1 : 0, STATS ? 48'h10 : 48'h0, STATS);
    end
    step();
    n_checks++;
    if (delta_valid !== 1'b0 || last_delta !== (STATS ? 48'h10 : 48'h0)) begin
      n_fail++; $display("FAIL delta_pulse dv=%b delta=%h exp 0 held", delta_valid, last_delta);
    end
    wait_idle("icm_load");
  endtask

  task automatic test_sw();
    icm_rdy = 0; sw_wr_req = 1; sw_wr_data = 48'h5;
    step(); sw_wr_req = 0; loads++;
    n_checks++;
    if (sw_wr_ack !== 1'b1 || sw_wr_nack !== 1'b0 || ltc_load !== 1'b1 || ltc_load_data !== 48'h6 || last_src !== 1'b1) begin
      n_fail++; $display("FAIL sw_accept ack=%b nack=%b load=%b data=%h src=%b exp 1 0 1 6 1",
        sw_wr_ack, sw_wr_nack, ltc_load, ltc_load_data, last_src);
    end
    step();
    n_checks++;
    if (sw_wr_ack !== 1'b0) begin n_fail++; $display("FAIL sw_ack_pulse ack=%b exp 0", sw_wr_ack); end
    wait_idle("sw_accept");
    icm_rdy = 1; sw_force = 0; sw_wr_req = 1; sw_wr_data = 48'h77;
    step(); sw_wr_req = 0;
    n_checks++;
    if (sw_wr_nack !== 1'b1 || sw_wr_ack !== 1'b0 || ltc_load !== 1'b0 || ltc_load_data !== 48'h6) begin
      n_fail++; $display("FAIL sw_nack nack=%b ack=%b load=%b data=%h exp 1 0 0 6",
        sw_wr_nack, sw_wr_ack, ltc_load, ltc_load_data);
    end
    step();
    n_checks++;
    if (sw_wr_nack !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sw_nack_pulse nack=%b busy=%b exp 0 0", sw_wr_nack, busy);
    end
    sw_force = 1; sw_wr_req = 1; sw_wr_data = 48'h100;
    step(); sw_wr_req = 0; sw_force = 0; loads++;
    n_checks++;
    if (sw_wr_ack !== 1'b1 || ltc_load !== 1'b1 || ltc_load_data !== 48'h101) begin
      n_fail++; $display("FAIL sw_force ack=%b load=%b data=%h exp 1 1 101", sw_wr_ack, ltc_load, ltc_load_data);
    end
    wait_idle("sw_force");
    icm_rdy = 0;
  endtask

  task automatic test_collision();
    icm_wr_req = 1; icm_wr_data = 48'hABC; sw_wr_req = 1; sw_wr_data = 48'h123;
    step(); icm_wr_req = 0; sw_wr_req = 0; loads++;
    n_checks++;
    if (ltc_load !== 1'b1 || ltc_load_data !== 48'hABD || last_src !== 1'b0 || sw_wr_nack !== 1'b1 || sw_wr_ack !== 1'b0) begin
      n_fail++; $display("FAIL collision load=%b data=%h src=%b nack=%b ack=%b exp 1 abd 0 1 0",
        ltc_load, ltc_load_data, last_src, sw_wr_nack, sw_wr_ack);
    end
    step();
    n_checks++;
    if (wr_cnt !== (STATS ? 16'(loads) : 16'd0)) begin
      n_fail++; $display("FAIL collision_cnt cnt=%0d exp %0d", wr_cnt, STATS ? loads : 0);
    end
    wait_idle("collision");
  endtask

  task automatic test_overrun();
    int n = 0;
    icm_wr_req = 1; icm_wr_data = 48'hA00;
    step(); loads++;
    icm_wr_data = 48'hB00; step();
    icm_wr_data = 48'hC00; step();
    icm_wr_data = 48'hD00; step();
    icm_wr_req = 0; n = 3;
    n_checks++;
    if (icm_overrun !== 1'b1 || busy !== 1'b1 || ltc_load !== 1'b0) begin
      n_fail++; $display("FAIL overrun ovr=%b busy=%b load=%b exp 1 1 0", icm_overrun, busy, ltc_load);
    end
    while (ltc_load !== 1'b1 && n < 60) begin step(); n++; end
    loads++;
    n_checks++;
    if (ltc_load !== 1'b1 || n != 2 + H || ltc_load_data !== 48'hD01) begin
      n_fail++; $display("FAIL overrun_reload load=%b after=%0d data=%h exp 1 %0d d01", ltc_load, n, ltc_load_data, 2 + H);
    end
    step();
    wait_idle("overrun");
  endtask

  task automatic test_wrap();
    ltc = 48'hFFFF_FFFF_FFFE; icm_wr_req = 1; icm_wr_data = 48'h0;
    step(); icm_wr_req = 0; ltc = 48'hFFFF_FFFF_FFFF; loads++;
    n_checks++;
    if (ltc_load !== 1'b1 || ltc_load_data !== 48'h1) begin
      n_fail++; $display("FAIL wrap_load load=%b data=%h exp 1 1", ltc_load, ltc_load_data);
    end
    step(); ltc = 48'h0;
    n_checks++;
    if (last_delta !== (STATS ? 48'h1 : 48'h0) || wr_cnt !== (STATS ? 16'(loads) : 16'd0)) begin
      n_fail++; $display("FAIL wrap_delta delta=%h cnt=%0d exp %h %0d", last_delta, wr_cnt, STATS ? 48'h1 : 48'h0, STATS ? loads : 0);
    end
    wait_idle("wrap");
  endtask

  task automatic test_reset_mid();
    sw_wr_req = 1; sw_wr_data = 48'h40;
    step(); sw_wr_req = 0;
    step(); step(); step();
    rst_n = 1'b0; #1; loads = 0;
    n_checks++;
    if ({ltc_load, sw_wr_ack, sw_wr_nack, busy, last_src, icm_overrun, delta_valid} !== 7'b0 ||
        ltc_load_data !== '0 || wr_cnt !== '0 || last_delta !== '0) begin
      n_fail++; $display("FAIL reset_mid load=%b busy=%b src=%b ovr=%b data=%h cnt=%0d delta=%h exp all 0",
        ltc_load, busy, last_src, icm_overrun, ltc_load_data, wr_cnt, last_delta);
    end
    step(); n_checks++;
    if (ltc_load !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_load load=%b busy=%b exp 0 0", ltc_load, busy);
    end
    rst_n = 1'b1; step();
    sw_wr_req = 1; sw_wr_data = 48'h900;
    step(); sw_wr_req = 0; loads++;
    n_checks++;
    if (ltc_load !== 1'b1 || sw_wr_ack !== 1'b1 || ltc_load_data !== 48'h901) begin
      n_fail++; $display("FAIL after_reset load=%b ack=%b data=%h exp 1 1 901", ltc_load, sw_wr_ack, ltc_load_data);
    end
    step(); n_checks++;
    if (wr_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL after_reset_cnt cnt=%0d exp %0d", wr_cnt, STATS ? 1 : 0);
    end
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_icm_load();
    test_sw();
    test_collision();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
